// File: rtl/vta_axi_mem_dpi_bridge.sv
// AXI4-style burst front end for the VTAMemDPI simulation memory.
// Serves one read or write burst at a time and turns it into DPI request/beat signals.
module vta_axi_mem_dpi_bridge #(
    parameter int LEN_BITS  = 8,
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 64
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ADDR_BITS-1:0] ar_addr,
    input  logic [LEN_BITS-1:0]  ar_len,

    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 r_last,

    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_BITS-1:0] aw_addr,
    input  logic [LEN_BITS-1:0]  aw_len,

    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 w_last,

    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [1:0]           b_resp,

    output logic                 dpi_req_valid,
    output logic                 dpi_req_opcode,
    output logic [LEN_BITS-1:0]  dpi_req_len,
    output logic [ADDR_BITS-1:0] dpi_req_addr,

    output logic                 dpi_wr_valid,
    output logic [DATA_BITS-1:0] dpi_wr_bits,

    input  logic                 dpi_rd_valid,
    input  logic [DATA_BITS-1:0] dpi_rd_bits,
    output logic                 dpi_rd_ready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_CMD  = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_CMD  = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] WR_ACK  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [LEN_BITS-1:0]  count;
    logic [LEN_BITS-1:0]  len_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 err;

    logic count_last;
    logic r_fire;
    logic w_fire;
    logic b_fire;

    // Count is compared before it increments, so len=max never needs a wider counter.
    assign count_last = (count == len_q);
    assign r_fire     = (state == RD_DATA) && dpi_rd_valid && r_ready;
    assign w_fire     = (state == WR_DATA) && w_valid;
    assign b_fire     = (state == WR_ACK) && b_ready;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (ar_valid)
                    state_next = RD_CMD;
                else if (aw_valid)
                    state_next = WR_CMD;
            end
            RD_CMD:  state_next = RD_DATA;
            RD_DATA: begin
                if (r_fire && count_last)
                    state_next = IDLE;
            end
            WR_CMD:  state_next = WR_DATA;
            WR_DATA: begin
                if (w_fire && count_last)
                    state_next = WR_ACK;
            end
            WR_ACK: begin
                if (b_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            len_q  <= '0;
            addr_q <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_next;

            if (state == IDLE) begin
                if (ar_valid) begin
                    addr_q <= ar_addr;
                    len_q  <= ar_len;
                end else if (aw_valid) begin
                    addr_q <= aw_addr;
                    len_q  <= aw_len;
                end
            end

            if (state == RD_CMD || state == WR_CMD)
                count <= '0;
            else if (r_fire || w_fire)
                count <= count + LEN_BITS'(1);

            // w_last is only checked against the length; it never ends a burst.
            if (w_fire && (w_last != count_last))
                err <= 1'b1;
            else if (b_fire)
                err <= 1'b0;
        end
    end

    always_comb begin
        ar_ready       = 1'b0;
        aw_ready       = 1'b0;
        r_valid        = 1'b0;
        r_data         = '0;
        r_last         = 1'b0;
        w_ready        = 1'b0;
        b_valid        = 1'b0;
        b_resp         = RESP_OKAY;
        dpi_req_valid  = 1'b0;
        dpi_req_opcode = 1'b0;
        dpi_wr_valid   = 1'b0;
        dpi_wr_bits    = '0;
        dpi_rd_ready   = 1'b0;

        unique case (state)
            IDLE: begin
                // Handshake readies stay low while reset is held.
                ar_ready = !reset;
                aw_ready = !reset && !ar_valid;
            end
            RD_CMD: begin
                dpi_req_valid  = 1'b1;
                dpi_req_opcode = 1'b0;
            end
            RD_DATA: begin
                r_valid      = dpi_rd_valid;
                r_data       = dpi_rd_bits;
                r_last       = count_last;
                dpi_rd_ready = r_ready;
            end
            WR_CMD: begin
                dpi_req_valid  = 1'b1;
                dpi_req_opcode = 1'b1;
            end
            WR_DATA: begin
                w_ready      = 1'b1;
                dpi_wr_valid = w_valid;
                dpi_wr_bits  = w_data;
            end
            WR_ACK: begin
                b_valid = 1'b1;
                b_resp  = err ? RESP_SLVERR : RESP_OKAY;
            end
            default: begin
                ar_ready = 1'b0;
            end
        endcase
    end

    assign dpi_req_len  = len_q;
    assign dpi_req_addr = addr_q;

endmodule

// File: tb/tb_vta_axi_mem_dpi_bridge.sv
// Directed bench for vta_axi_mem_dpi_bridge.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_vta_axi_mem_dpi_bridge;

    localparam int LB = 8;
    localparam int AB = 64;
    localparam int DB = 64;

    logic          clock;
    logic          reset;
    logic          ar_valid;
    logic          ar_ready;
    logic [AB-1:0] ar_addr;
    logic [LB-1:0] ar_len;
    logic          r_valid;
    logic          r_ready;
    logic [DB-1:0] r_data;
    logic          r_last;
    logic          aw_valid;
    logic          aw_ready;
    logic [AB-1:0] aw_addr;
    logic [LB-1:0] aw_len;
    logic          w_valid;
    logic          w_ready;
    logic [DB-1:0] w_data;
    logic          w_last;
    logic          b_valid;
    logic          b_ready;
    logic [1:0]    b_resp;
    logic          dpi_req_valid;
    logic          dpi_req_opcode;
    logic [LB-1:0] dpi_req_len;
    logic [AB-1:0] dpi_req_addr;
    logic          dpi_wr_valid;
    logic [DB-1:0] dpi_wr_bits;
    logic          dpi_rd_valid;
    logic [DB-1:0] dpi_rd_bits;
    logic          dpi_rd_ready;

    int n_tests = 0;
    int n_fail  = 0;

    vta_axi_mem_dpi_bridge #(
        .LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB)
    ) dut (
        .clock(clock), .reset(reset),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready),
        .r_data(r_data), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .dpi_req_valid(dpi_req_valid),
        .dpi_req_opcode(dpi_req_opcode),
        .dpi_req_len(dpi_req_len),
        .dpi_req_addr(dpi_req_addr),
        .dpi_wr_valid(dpi_wr_valid), .dpi_wr_bits(dpi_wr_bits),
        .dpi_rd_valid(dpi_rd_valid), .dpi_rd_bits(dpi_rd_bits),
        .dpi_rd_ready(dpi_rd_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        #1;
        n_tests++;
        if ({ar_ready, aw_ready, r_valid, b_valid, dpi_req_valid,
             dpi_wr_valid, dpi_rd_ready, w_ready} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 00000000",
                     {ar_ready, aw_ready, r_valid, b_valid, dpi_req_valid,
                      dpi_wr_valid, dpi_rd_ready, w_ready});
        end
        n_tests++;
        if (dpi_req_addr !== 64'h0 || dpi_req_len !== 8'h0 || b_resp !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got addr=%h len=%h resp=%0d expected 0 0 0",
                     dpi_req_addr, dpi_req_len, b_resp);
        end
        step();
        reset = 1'b0;
        #1;
        n_tests++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got ar=%b aw=%b expected 1 1", ar_ready, aw_ready);
        end
    endtask

    task automatic test_read_single(input logic [AB-1:0] addr, input logic [DB-1:0] d);
        step();
        ar_valid = 1'b1; ar_addr = addr; ar_len = 8'd0;
        #1;
        n_tests++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd1_ar: got ar_ready=%b aw_ready=%b expected 1 0", ar_ready, aw_ready);
        end
        step();
        ar_valid = 1'b0; ar_addr = '0;
        #1;
        n_tests++;
        if ({dpi_req_valid, dpi_req_opcode} !== 2'b10 || dpi_req_len !== 8'd0 ||
            dpi_req_addr !== addr) begin
            n_fail++;
            $display("FAIL rd1_req: got v/op=%b len=%h addr=%h expected 10 00 %h",
                     {dpi_req_valid, dpi_req_opcode}, dpi_req_len, dpi_req_addr, addr);
        end
        // DPI not ready yet on the first data cycle.
        step();
        r_ready = 1'b1; dpi_rd_valid = 1'b0;
        #1;
        n_tests++;
        if (r_valid !== 1'b0 || dpi_req_valid !== 1'b0 || dpi_rd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd1_wait: got r_valid=%b req=%b rd_ready=%b expected 0 0 1",
                     r_valid, dpi_req_valid, dpi_rd_ready);
        end
        step();
        dpi_rd_valid = 1'b1; dpi_rd_bits = d;
        #1;
        n_tests++;
        if (r_valid !== 1'b1 || r_data !== d || r_last !== 1'b1) begin
            n_fail++;
            $display("FAIL rd1_beat: got v=%b data=%h last=%b expected 1 %h 1",
                     r_valid, r_data, r_last, d);
        end
        // Stray DPI beat in IDLE must not leak out.
        step();
        dpi_rd_bits = 64'hDEAD;
        #1;
        n_tests++;
        if (r_valid !== 1'b0 || dpi_rd_ready !== 1'b0 || ar_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd1_stray: got r_valid=%b rd_ready=%b ar_ready=%b expected 0 0 1",
                     r_valid, dpi_rd_ready, ar_ready);
        end
        dpi_rd_valid = 1'b0; r_ready = 1'b0;
    endtask

    task automatic test_read_burst();
        logic [DB-1:0] vals [4];
        int b;
        vals[0] = 64'h1111_0000; vals[1] = 64'h2222_0001;
        vals[2] = 64'h3333_0002; vals[3] = 64'h4444_0003;
        step();
        ar_valid = 1'b1; ar_addr = 64'h3000; ar_len = 8'd3;
        step();
        ar_valid = 1'b0;
        #1;
        n_tests++;
        if (dpi_req_valid !== 1'b1 || dpi_req_len !== 8'd3 || dpi_req_addr !== 64'h3000) begin
            n_fail++;
            $display("FAIL rd4_req: got v=%b len=%h addr=%h expected 1 03 3000",
                     dpi_req_valid, dpi_req_len, dpi_req_addr);
        end
        b = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            r_ready = (c % 2 == 0);
            dpi_rd_valid = 1'b1;
            dpi_rd_bits = vals[b];
            #1;
            n_tests++;
            if (r_valid !== 1'b1 || r_data !== vals[b] || dpi_rd_ready !== r_ready ||
                r_last !== (b == 3)) begin
                n_fail++;
                $display("FAIL rd4_beat%0d: got v=%b data=%h rdy=%b last=%b expected 1 %h %b %b",
                         c, r_valid, r_data, dpi_rd_ready, r_last, vals[b], r_ready, (b == 3));
            end
            if (r_ready) b++;
        end
        step();
        dpi_rd_valid = 1'b0; r_ready = 1'b0;
        #1;
        n_tests++;
        if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd4_done: got ar_ready=%b r_valid=%b expected 1 0", ar_ready, r_valid);
        end
    endtask

    task automatic run_write(input string nm, input logic [AB-1:0] addr,
                             input logic last0, input logic last1,
                             input logic [1:0] exp_resp);
        step();
        aw_valid = 1'b1; aw_addr = addr; aw_len = 8'd1;
        #1;
        n_tests++;
        if (aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_aw: got aw_ready=%b expected 1", nm, aw_ready);
        end
        step();
        aw_valid = 1'b0;
        #1;
        n_tests++;
        if ({dpi_req_valid, dpi_req_opcode} !== 2'b11 || dpi_req_len !== 8'd1 ||
            dpi_req_addr !== addr) begin
            n_fail++;
            $display("FAIL %s_req: got v/op=%b len=%h addr=%h expected 11 01 %h",
                     nm, {dpi_req_valid, dpi_req_opcode}, dpi_req_len, dpi_req_addr, addr);
        end
        step();
        w_valid = 1'b1; w_data = 64'h11; w_last = last0;
        #1;
        n_tests++;
        if (w_ready !== 1'b1 || dpi_wr_valid !== 1'b1 || dpi_wr_bits !== 64'h11) begin
            n_fail++;
            $display("FAIL %s_w0: got rdy=%b v=%b bits=%h expected 1 1 11",
                     nm, w_ready, dpi_wr_valid, dpi_wr_bits);
        end
        // Bubble: no beat offered, burst must wait.
        step();
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        n_tests++;
        if (w_ready !== 1'b1 || dpi_wr_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_gap: got rdy=%b v=%b b=%b expected 1 0 0",
                     nm, w_ready, dpi_wr_valid, b_valid);
        end
        step();
        w_valid = 1'b1; w_data = 64'h22; w_last = last1;
        #1;
        n_tests++;
        if (dpi_wr_valid !== 1'b1 || dpi_wr_bits !== 64'h22 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_w1: got v=%b bits=%h b=%b expected 1 22 0",
                     nm, dpi_wr_valid, dpi_wr_bits, b_valid);
        end
        step();
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
        #1;
        n_tests++;
        if (b_valid !== 1'b1 || b_resp !== exp_resp || w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_b: got b_valid=%b resp=%0d w_ready=%b expected 1 %0d 0",
                     nm, b_valid, b_resp, w_ready, exp_resp);
        end
        step();
        b_ready = 1'b1;
        #1;
        n_tests++;
        if (b_valid !== 1'b1 || b_resp !== exp_resp) begin
            n_fail++;
            $display("FAIL %s_bhold: got b_valid=%b resp=%0d expected 1 %0d",
                     nm, b_valid, b_resp, exp_resp);
        end
        step();
        b_ready = 1'b0;
        #1;
        n_tests++;
        if (b_valid !== 1'b0 || ar_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: got b_valid=%b ar_ready=%b expected 0 1",
                     nm, b_valid, ar_ready);
        end
    endtask

    task automatic test_write();
        run_write("wr_ok", 64'h2000, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_write_err();
        run_write("wr_err", 64'h2400, 1'b1, 1'b0, 2'd2);
        run_write("wr_clr", 64'h2800, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_priority();
        step();
        ar_valid = 1'b1; ar_addr = 64'h5000; ar_len = 8'd0;
        aw_valid = 1'b1; aw_addr = 64'h6000; aw_len = 8'd0;
        #1;
        n_tests++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pri_tie: got ar=%b aw=%b expected 1 0", ar_ready, aw_ready);
        end
        step();
        ar_valid = 1'b0;
        #1;
        n_tests++;
        if (dpi_req_opcode !== 1'b0 || dpi_req_addr !== 64'h5000 || aw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pri_rdcmd: got op=%b addr=%h aw=%b expected 0 5000 0",
                     dpi_req_opcode, dpi_req_addr, aw_ready);
        end
        step();
        dpi_rd_valid = 1'b1; dpi_rd_bits = 64'h77; r_ready = 1'b1;
        #1;
        n_tests++;
        if (r_last !== 1'b1 || r_data !== 64'h77 || aw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pri_rdbeat: got last=%b data=%h aw=%b expected 1 77 0",
                     r_last, r_data, aw_ready);
        end
        step();
        dpi_rd_valid = 1'b0; r_ready = 1'b0;
        #1;
        n_tests++;
        if (aw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pri_aw: got aw_ready=%b expected 1", aw_ready);
        end
        step();
        aw_valid = 1'b0;
        #1;
        n_tests++;
        if (dpi_req_opcode !== 1'b1 || dpi_req_addr !== 64'h6000) begin
            n_fail++;
            $display("FAIL pri_wrcmd: got op=%b addr=%h expected 1 6000",
                     dpi_req_opcode, dpi_req_addr);
        end
        step();
        w_valid = 1'b1; w_data = 64'h99; w_last = 1'b1;
        step();
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        #1;
        n_tests++;
        if (b_valid !== 1'b1 || b_resp !== 2'd0) begin
            n_fail++;
            $display("FAIL pri_b: got b_valid=%b resp=%0d expected 1 0", b_valid, b_resp);
        end
        step();
        b_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        ar_valid = 1'b1; ar_addr = 64'h7000; ar_len = 8'd3;
        step();
        ar_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            dpi_rd_valid = 1'b1; dpi_rd_bits = 64'(i); r_ready = 1'b1;
        end
        step();
        dpi_rd_bits = 64'h2;
        #1;
        n_tests++;
        if (r_valid !== 1'b1 || r_data !== 64'h2 || r_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got v=%b data=%h last=%b expected 1 2 0",
                     r_valid, r_data, r_last);
        end
        reset = 1'b1;
        step();
        #1;
        n_tests++;
        if ({ar_ready, aw_ready, r_valid, dpi_rd_ready, dpi_req_valid, b_valid} !== 6'h00 ||
            dpi_req_addr !== 64'h0 || dpi_req_len !== 8'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got ctl=%b addr=%h len=%h expected 000000 0 0",
                     {ar_ready, aw_ready, r_valid, dpi_rd_ready, dpi_req_valid, b_valid},
                     dpi_req_addr, dpi_req_len);
        end
        reset = 1'b0;
        dpi_rd_valid = 1'b0; r_ready = 1'b0;
        #1;
        n_tests++;
        if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got ar_ready=%b r_valid=%b expected 1 0",
                     ar_ready, r_valid);
        end
        test_read_single(64'h8000, 64'h5A);
    endtask

    initial begin
        reset = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; ar_len = '0;
        r_ready = 1'b0;
        aw_valid = 1'b0; aw_addr = '0; aw_len = '0;
        w_valid = 1'b0; w_data = '0; w_last = 1'b0;
        b_ready = 1'b0;
        dpi_rd_valid = 1'b0; dpi_rd_bits = '0;

        test_reset();
        test_read_single(64'h1000, 64'hA5);
        test_read_burst();
        test_write();
        test_write_err();
        test_priority();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
